// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl shared definitions: state codes, opcodes and small helpers.
// The `define copies mirror the enum for the cs decoder's defines users.
`ifndef SEQ_CTRL_DEFS
`define SEQ_CTRL_DEFS
`define S_IDLE          4'd0
`define S_FETCH         4'd1
`define S_WAIT_ROM      4'd2
`define S_DECODE        4'd3
`define S_ULA_OP        4'd4
`define S_STORE_ULA_RES 4'd5
`define S_STORE_REGA    4'd6
`define S_HALT          4'd7
`define OP_NOP          4'h0
`define OP_HALT         4'hF
`endif

package seq_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE          = 4'd0,
      S_FETCH         = 4'd1,
      S_WAIT_ROM      = 4'd2,
      S_DECODE        = 4'd3,
      S_ULA_OP        = 4'd4,
      S_STORE_ULA_RES = 4'd5,
      S_STORE_REGA    = 4'd6,
      S_HALT          = 4'd7
   } state_t;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_HALT = 4'hF;

   function automatic logic is_busy(input logic [3:0] s);
      return !((s == 4'd0) || (s == 4'd7));
   endfunction

endpackage

// File: rtl/seq_ctrl_if.sv
// Sequencer control bus: start/ROM handshake in, state and status out.
interface seq_ctrl_if;

   logic       start;
   logic [3:0] rom_data;
   logic       rom_ready;
   logic [3:0] state;
   logic [3:0] opcode;
   logic       busy;
   logic       fault;
   logic [7:0] instr_count;

   modport master (
      output start, rom_data, rom_ready,
      input  state, opcode, busy, fault, instr_count
   );

   modport slave (
      input  start, rom_data, rom_ready,
      output state, opcode, busy, fault, instr_count
   );

endinterface

// File: rtl/seq_ctrl_wait_timer.sv
// 8-bit clear/enable counter; o_tc flags the last allowed count.
module seq_ctrl_wait_timer #(
   parameter int LIMIT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam logic [7:0] TC = 8'(LIMIT - 1);

   logic [7:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clr)
         r_cnt <= 8'd0;
      else if (i_en)
         r_cnt <= r_cnt + 8'd1;
   end

   assign o_tc = (r_cnt == TC);

endmodule

// File: rtl/seq_ctrl.sv
// processinho main sequencer: fetch/decode/ALU/writeback loop with
// opcode latch, ROM ready handshake, timeout fault and retire counter.
module seq_ctrl
   import seq_ctrl_pkg::*;
#(
   parameter int ROM_TIMEOUT = 15
) (
   input logic       clk,
   input logic       rst,
   seq_ctrl_if.slave bus
);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_opcode;
   logic [7:0] r_count;
   logic       r_fault;
   logic       w_waiting;
   logic       w_tc;
   logic       w_latch;
   logic       w_retire;
   logic       w_set_fault;

   assign w_waiting = (r_state == S_WAIT_ROM);

   // Held clear outside S_WAIT_ROM, so every entry starts from zero
   seq_ctrl_wait_timer #(
      .LIMIT (ROM_TIMEOUT)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .i_clr (!w_waiting),
      .i_en  (w_waiting),
      .o_tc  (w_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_opcode <= 4'h0;
         r_count  <= 8'd0;
         r_fault  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_latch)
            r_opcode <= bus.rom_data;
         if (w_retire)
            r_count <= r_count + 8'd1;
         if (w_set_fault)
            r_fault <= 1'b1;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_latch     = 1'b0;
      w_retire    = 1'b0;
      w_set_fault = 1'b0;
      case (r_state)
         S_IDLE:
            if (bus.start)
               w_next = S_FETCH;
         S_FETCH:
            w_next = S_WAIT_ROM;
         S_WAIT_ROM:
            if (bus.rom_ready) begin
               w_latch = 1'b1;
               w_next  = S_DECODE;
            end else if (w_tc) begin
               w_set_fault = 1'b1;
               w_next      = S_HALT;
            end
         S_DECODE:
            if (r_opcode == OP_HALT) begin
               w_retire = 1'b1;
               w_next   = S_HALT;
            end else if (r_opcode == OP_NOP) begin
               w_retire = 1'b1;
               w_next   = S_FETCH;
            end else begin
               w_next = S_ULA_OP;
            end
         S_ULA_OP:
            w_next = S_STORE_ULA_RES;
         S_STORE_ULA_RES:
            w_next = S_STORE_REGA;
         S_STORE_REGA: begin
            w_retire = 1'b1;
            w_next   = S_FETCH;
         end
         S_HALT:
            if (bus.start && !r_fault)
               w_next = S_FETCH;
         default:
            w_next = S_IDLE;
      endcase
   end

   assign bus.state       = r_state;
   assign bus.opcode      = r_opcode;
   assign bus.busy        = is_busy(r_state);
   assign bus.fault       = r_fault;
   assign bus.instr_count = r_count;

endmodule

// File: doc/seq_ctrl.md
# seq_ctrl

Main sequencer for the processinho core. Generates the 4-bit `state` code that the control-signal decoder `cs` turns into read, write, latch and PC strobes. It also latches the fetched opcode and handles the ROM ready handshake with a timeout. It runs the fetch → decode → ALU → writeback loop, and it stops on a HALT opcode or on a ROM fault.

## Interface
- `ROM_TIMEOUT`, default 15: the maximum number of cycles spent in S_WAIT_ROM before a fault is declared. Legal range is 1–255.
- `clk` input, 1 bit: the single clock. All state changes on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: a level sampled each cycle. It leaves S_IDLE, or leaves a non-fault S_HALT.
- `rom_data` input, 4 bits: the opcode nibble from instruction ROM. Valid when `rom_ready` is 1.
- `rom_ready` input, 1 bit: ROM data is valid this cycle.
- `state` output, 4 bits: the current state code. Drives `cs.state`.
- `opcode` output, 4 bits: the latched opcode. Drives `cs.opcode`.
- `busy` output, 1 bit: 1 in every state except S_IDLE and S_HALT.
- `fault` output, 1 bit: sticky ROM-timeout flag.
- `instr_count` output, 8 bits: the number of retired instructions. Wraps modulo 256.

## Operation
- State encodings, fixed:
  - S_IDLE = 0
  - S_FETCH = 1
  - S_WAIT_ROM = 2
  - S_DECODE = 3
  - S_ULA_OP = 4
  - S_STORE_ULA_RES = 5
  - S_STORE_REGA = 6
  - S_HALT = 7
  - Codes 8–15 are illegal.
- Opcodes:
  - OP_NOP = 4'h0
  - OP_HALT = 4'hF
  - Every other value is an ALU operation, passed to `cs` unchanged.
- Transitions:
  - S_IDLE → S_FETCH when `start` = 1; otherwise stay in S_IDLE.
  - S_FETCH → S_WAIT_ROM, always. S_FETCH lasts exactly one cycle, so `cs` emits one `pc_increment`/`rom_read` pulse per instruction.
  - S_WAIT_ROM:
    - If `rom_ready` = 1: latch `rom_data` into `opcode` and go to S_DECODE.
    - Else if the wait counter equals ROM_TIMEOUT−1: set `fault` and go to S_HALT.
    - Else increment the wait counter.
  - S_DECODE, by the latched opcode:
    - OP_HALT → S_HALT.
    - OP_NOP → S_FETCH, with `instr_count` +1.
    - Any other value → S_ULA_OP.
  - S_ULA_OP → S_STORE_ULA_RES → S_STORE_REGA → S_FETCH. `instr_count` +1 on leaving S_STORE_REGA.
  - S_HALT (reached by OP_HALT): `instr_count` +1 on entry. Leave to S_FETCH when `start` = 1 and `fault` = 0. With `fault` = 1, the only exit is `rst`.
  - Illegal state code → S_IDLE on the next edge. `fault` and `instr_count` are unchanged.
- Wait counter:
  - 8 bits.
  - Cleared on every entry to S_WAIT_ROM.
  - Counts only while in S_WAIT_ROM.
- `opcode` changes only on the S_WAIT_ROM handshake cycle. It holds its value through S_HALT and S_IDLE.
- `busy` is decoded combinationally from `state`.

## Timing
- Reset values:
  - `state` = S_IDLE
  - `opcode` = 4'h0
  - `fault` = 0
  - `instr_count` = 0
  - wait counter = 0
  - `busy` = 0
- `rst` mid-instruction aborts the instruction. On the next edge every register takes its reset value. A partial instruction is not counted.
- Minimum cycle counts (`rom_ready` high on the first cycle of S_WAIT_ROM), from S_FETCH to the next S_FETCH:
  - ALU instruction: 6 cycles.
  - NOP: 3 cycles.
- Each ROM wait cycle without `rom_ready` adds 1 cycle.
- Timeout: with `rom_ready` held low, S_WAIT_ROM lasts exactly ROM_TIMEOUT cycles, then S_HALT with `fault` = 1.
- If `rom_ready` = 1 on the final allowed wait cycle, the handshake wins and no fault is raised.
- `start` held high in S_HALT (no fault) restarts on the next edge. The bench must not rely on a pulse width.
- `instr_count` wraps from 255 to 0 with no flag.
- `rom_data` is ignored outside S_WAIT_ROM.

## Structure
- Add the following to the shared defines file already used by `cs`, as `define`s:
  - all S_* state codes, including S_IDLE, S_WAIT_ROM, S_DECODE and S_HALT;
  - OP_NOP and OP_HALT.
- Register layout:
  - one state register;
  - one opcode register;
  - one wait counter;
  - one instruction counter;
  - `fault` flop.
- Next-state logic is a single combinational case statement.
- Optional sub-module `wait_timer` (8-bit clear/enable counter with terminal-count output) for the ROM timeout. Everything else stays flat.

## Test plan
- Reset, then `start` = 1 for 1 cycle. ROM returns 4'h3 with `rom_ready` on the first wait cycle.
  - Required: state sequence 0,1,2,3,4,5,6,1.
  - `opcode` = 4'h3 from the S_DECODE cycle onward.
  - `instr_count` = 1 when S_FETCH is re-entered.
- Program NOP, NOP, HALT with zero ROM wait.
  - Required: S_HALT reached 9 cycles after the first S_FETCH.
  - `instr_count` = 3, `busy` = 0, `fault` = 0.
- `rom_ready` held low with ROM_TIMEOUT = 4.
  - Required: exactly 4 cycles in S_WAIT_ROM, then S_HALT with `fault` = 1.
  - `start` = 1 afterwards leaves the state at 7.
  - `rst` clears everything to the reset values.
- Same setup, with `rom_ready` = 1 on the 4th wait cycle and data 4'h2.
  - Required: S_DECODE, `fault` = 0, `opcode` = 4'h2.
- Assert `rst` while in S_STORE_ULA_RES after 10 retired instructions.
  - Required: next cycle `state` = 0, `instr_count` = 0, `opcode` = 0.
- Run 256 NOPs, with `instr_count` preloaded by running 255 first.
  - Required: the count wraps from 255 to 0.
- Force `state` to 4'hB.
  - Required: state = 0 on the next edge, `fault` unchanged.
